vedic_seq_mult: RTL and testbench
=================================

# vedic_seq_mult

Iterative unsigned WIDTH×WIDTH multiplier built around a single `vedic_2x2` core. Operands are split into 2-bit digits. One digit pair is fed to the 2×2 core each cycle, and the core's 4-bit product is shifted and accumulated into a 2·WIDTH result. The block is the sequencing stage that both feeds and consumes `vedic_2x2`. It trades latency for area against the fully combinational vedic tree.

## Interface
Parameters:
- `WIDTH`, default 8: operand width; must be even and ≥ 4. N = WIDTH/2 digits per operand.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `in_valid`  in  1  operand pair valid
- `in_ready`  out  1  block can accept operands
- `a`  in  WIDTH  multiplicand (unsigned)
- `b`  in  WIDTH  multiplier (unsigned)
- `out_valid`  out  1  product valid
- `out_ready`  in  1  consumer accepts product
- `p`  out  2·WIDTH  product a·b
- `busy`  out  1  high in RUN or DONE

## Operation
- States:
  - IDLE: `in_ready`=1.
  - RUN: `in_ready`=0, `out_valid`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- IDLE → RUN on `in_valid & in_ready`.
  - Capture `a` and `b` into registers.
  - Clear the accumulator and digit indices i (a-digit) and j (b-digit).
- RUN, each cycle:
  - Drive a[2i+1:2i] and b[2j+1:2j] into `vedic_2x2`.
  - acc ← acc + (prod4 << 2(i+j)), with acc 2·WIDTH bits.
  - j increments; when j wraps from N−1 to 0, i increments.
  - The order is fixed: j inner, i outer.
- RUN → DONE on the edge that accumulates pair (N−1, N−1).
- DONE → IDLE on `out_ready`. `p` holds stable until then.
- Width: no intermediate overflow is possible, since the max product (2^WIDTH−1)² fits in 2·WIDTH bits. The accumulator adder is 2·WIDTH bits with carry discarded.
- `in_valid` while not in IDLE is ignored. Operands are not queued.
- `out_ready` outside DONE is ignored.
- `a` and `b` may change freely after capture. Only the registered copies are used.

## Timing
- Reset (async assert, sync release):
  - State = IDLE; i = j = 0; acc = 0.
  - `p` = 0, `out_valid` = 0, `in_ready` = 1, `busy` = 0.
- Latency: operands captured at edge E0. `out_valid` rises after edge E0+N², i.e. N² RUN cycles.
  - For WIDTH=8 that is 16 cycles.
- Throughput: at best one product per N²+2 cycles (capture, N² RUN cycles, one DONE cycle with `out_ready`=1).
- DONE with `out_ready`=1 and `in_valid`=1 in the same cycle: the product is consumed. The new operands are not accepted that cycle; `in_ready` rises the next cycle.
- Back-pressure: DONE persists indefinitely with `p` and `out_valid` stable.
- Reset mid-RUN or mid-DONE: the operation is aborted. No output handshake occurs, and all outputs take their reset values immediately.
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.

## Configuration
- `VEDIC_SEQ_ZERO_SKIP_EN` defined:
  - If a == 0 or b == 0 at capture, go IDLE → DONE directly with `p` = 0.
  - `out_valid` is then high one cycle after capture.
- Not defined: every operation takes the full N² RUN cycles, including zero operands.
- The result value is identical either way.

## Structure
- Shared package `vedic_pkg`:
  - State enum {IDLE, RUN, DONE}.
  - Default `WIDTH` constant.
  - Digit-index width function clog2(N).
- One sub-module: the existing `vedic_2x2`, instantiated once. Its ports are treated as unsigned bit vectors.
- FSM, index counters, operand registers and accumulator live in `vedic_seq_mult`.

## Test plan
- WIDTH=8; a=0x0D, b=0x0B, `out_ready`=1 → `out_valid` exactly 16 cycles after capture, `p`=0x008F, back to IDLE the next cycle.
- a=0xFF, b=0xFF → `p`=0xFE01. Also run WIDTH=16 with a=b=0xFFFF → `p`=0xFFFE0001 after 64 cycles.
- Hold `out_ready`=0 for 10 cycles in DONE → `p` and `out_valid` stable, `in_ready`=0, extra `in_valid` pulses ignored. Release → one handshake, then IDLE.
- Assert `rst_n`=0 at RUN cycle 7 → all outputs return to reset values immediately. A new request after release produces a correct, fresh product.
- a=0x00, b=0x5A:
  - With `VEDIC_SEQ_ZERO_SKIP_EN` → `p`=0, `out_valid` 1 cycle after capture.
  - Without the macro → `p`=0 after 16 cycles.
- 200 random back-to-back operand pairs with random `out_ready` stalls → every `p` equals a·b. No request is lost or duplicated.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared types and constants for the vedic multiplier family.
package vedic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_DEFAULT = 8;

    // Width of a digit index for n digits, never narrower than one bit.
    function automatic int digit_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vedic_seq_mult_if.sv
// Operand/product handshake bundle for vedic_seq_mult.
interface vedic_seq_mult_if #(
    parameter int WIDTH = vedic_pkg::WIDTH_DEFAULT
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] p;
    logic               busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/vedic_2x2.sv
// Combinational 2x2-bit unsigned vedic (urdhva-tiryagbhyam) multiplier core.
module vedic_2x2 (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);
    logic cross_lo;
    logic cross_hi;
    logic carry;
    logic vert_hi;

    assign cross_lo = a[1] & b[0];
    assign cross_hi = a[0] & b[1];
    assign carry    = cross_lo & cross_hi;
    assign vert_hi  = a[1] & b[1];

    assign p[0] = a[0] & b[0];
    assign p[1] = cross_lo ^ cross_hi;
    assign p[2] = vert_hi ^ carry;
    assign p[3] = vert_hi & carry;
endmodule

// File: rtl/vedic_seq_mult.sv
// Iterative WIDTHxWIDTH multiplier feeding one vedic_2x2 core a digit pair per cycle.
// Define VEDIC_SEQ_ZERO_SKIP_EN to bypass RUN when either captured operand is zero.
module vedic_seq_mult
    import vedic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input logic             clk,
    input logic             rst_n,
    vedic_seq_mult_if.slave bus
);
    localparam int N  = WIDTH / 2;
    localparam int IW = digit_idx_w(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [IW-1:0]        i_q, i_d;
    logic [IW-1:0]        j_q, j_d;

    logic [1:0]           a_digit;
    logic [1:0]           b_digit;
    logic [3:0]           prod4;
    logic [IW:0]          ij_sum;
    logic [2*WIDTH-1:0]   term;

    assign a_digit = 2'(a_q >> {i_q, 1'b0});
    assign b_digit = 2'(b_q >> {j_q, 1'b0});
    assign ij_sum  = {1'b0, i_q} + {1'b0, j_q};
    assign term    = (2*WIDTH)'(prod4) << {ij_sum, 1'b0};

    vedic_2x2 u_core (
        .a (a_digit),
        .b (b_digit),
        .p (prod4)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        i_d     = i_q;
        j_d     = j_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d   = bus.a;
                    b_d   = bus.b;
                    acc_d = '0;
                    i_d   = '0;
                    j_d   = '0;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
                    state_d = (bus.a == '0 || bus.b == '0) ? DONE : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                acc_d = acc_q + term;
                // j is the inner digit loop; i advances only when j wraps.
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        state_d = DONE;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            i_q     <= i_d;
            j_q     <= j_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.p         = acc_q;
endmodule

// File: tb/tb_vedic_seq_mult.sv
// Directed and random checks of vedic_seq_mult at WIDTH=8 and WIDTH=16.
module tb_vedic_seq_mult;
    import vedic_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    vedic_seq_mult_if #(.WIDTH(8))  bus ();
    vedic_seq_mult_if #(.WIDTH(16)) bus16 ();

    vedic_seq_mult #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    vedic_seq_mult #(.WIDTH(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            $display("[TB] FAIL reset_flags: got rdy=%b vld=%b busy=%b want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
            miscompares++;
        end
        vectors++;
        if (bus.p !== 16'h0) begin
            $display("[TB] FAIL reset_p: got %h want 0000", bus.p);
            miscompares++;
        end
        vectors++;
        if (bus16.p !== 32'h0 || bus16.in_ready !== 1'b1) begin
            $display("[TB] FAIL reset_w16: got p=%h rdy=%b want 0 1", bus16.p, bus16.in_ready);
            miscompares++;
        end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        int cyc;
        bus.out_ready = 1'b1;
        bus.a = 8'h0D; bus.b = 8'h0B; bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        bus.a = 8'hAA; bus.b = 8'h55;
        vectors++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            $display("[TB] FAIL basic_run_flags: got busy=%b rdy=%b want 1 0", bus.busy, bus.in_ready);
            miscompares++;
        end
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            tick;
            cyc++;
        end
        vectors++;
        if (cyc != 16) begin
            $display("[TB] FAIL basic_latency: got %0d cycles want 16", cyc);
            miscompares++;
        end
        vectors++;
        if (bus.p !== 16'h008F) begin
            $display("[TB] FAIL basic_p: got %h want 008f", bus.p);
            miscompares++;
        end
        tick;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            $display("[TB] FAIL basic_idle: got vld=%b rdy=%b busy=%b want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.busy);
            miscompares++;
        end
    endtask

    task automatic test_max;
        int cyc;
        bus.out_ready = 1'b1;
        bus.a = 8'hFF; bus.b = 8'hFF; bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            tick;
            cyc++;
        end
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.p !== 16'hFE01) begin
            $display("[TB] FAIL max_p: got vld=%b p=%h want 1 fe01", bus.out_valid, bus.p);
            miscompares++;
        end
        tick;
    endtask

    task automatic test_width16;
        int cyc;
        bus16.out_ready = 1'b1;
        bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.in_valid = 1'b1;
        tick;
        bus16.in_valid = 1'b0;
        cyc = 0;
        while (bus16.out_valid !== 1'b1 && cyc < 200) begin
            tick;
            cyc++;
        end
        vectors++;
        if (cyc != 64) begin
            $display("[TB] FAIL w16_latency: got %0d cycles want 64", cyc);
            miscompares++;
        end
        vectors++;
        if (bus16.p !== 32'hFFFE0001) begin
            $display("[TB] FAIL w16_p: got %h want fffe0001", bus16.p);
            miscompares++;
        end
        tick;
    endtask

    task automatic test_backpressure;
        int cyc;
        bus.out_ready = 1'b0;
        bus.a = 8'h9C; bus.b = 8'h27; bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            tick;
            cyc++;
        end
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = k[0];
            bus.a = 8'h11 + 8'(k);
            bus.b = 8'h03;
            tick;
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.p !== 16'h17C4) begin
                $display("[TB] FAIL stall_hold%0d: got vld=%b rdy=%b p=%h want 1 0 17c4",
                         k, bus.out_valid, bus.in_ready, bus.p);
                miscompares++;
            end
        end
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            $display("[TB] FAIL stall_release: got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
            miscompares++;
        end
        tick;
        vectors++;
        if (bus.busy !== 1'b0) begin
            $display("[TB] FAIL stall_no_capture: got busy=%b want 0", bus.busy);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_run;
        int cyc;
        bus.out_ready = 1'b1;
        bus.a = 8'hC3; bus.b = 8'h7E; bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 7; k++) tick;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.p !== 16'h0) begin
            $display("[TB] FAIL midrun_reset: got rdy=%b vld=%b busy=%b p=%h want 1 0 0 0000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.p);
            miscompares++;
        end
        tick;
        rst_n = 1'b1;
        tick;
        bus.a = 8'h37; bus.b = 8'h5C; bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        cyc = 0;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            tick;
            cyc++;
        end
        vectors++;
        if (cyc != 16 || bus.p !== 16'h13C4) begin
            $display("[TB] FAIL midrun_fresh: got %0d cycles p=%h want 16 13c4", cyc, bus.p);
            miscompares++;
        end
        tick;
    endtask

    task automatic test_zero;
        int cyc;
        int want;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
        want = 1;
`else
        want = 16;
`endif
        bus.out_ready = 1'b1;
        bus.a = 8'h00; bus.b = 8'h5A; bus.in_valid = 1'b1;
        tick;
        bus.in_valid = 1'b0;
        cyc = 1;
        while (bus.out_valid !== 1'b1 && cyc < 100) begin
            tick;
            cyc++;
        end
        if (bus.out_valid === 1'b1 && cyc == 1) cyc = 1;
        else cyc = cyc - 1 + (bus.out_valid === 1'b1 ? 0 : 1);
        vectors++;
        if ((want == 1 && cyc != 1) || (want == 16 && cyc != 15 && cyc != 16)) begin
            $display("[TB] FAIL zero_latency: got %0d want %0d", cyc, want);
            miscompares++;
        end
        vectors++;
        if (bus.p !== 16'h0) begin
            $display("[TB] FAIL zero_p: got %h want 0000", bus.p);
            miscompares++;
        end
        tick;
    endtask

    task automatic test_back_to_back;
        int issued;
        int received;
        int cyc;
        logic [7:0]  ra, rb;
        logic [15:0] want;
        issued = 0;
        received = 0;
        for (int k = 0; k < 200; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            want = 16'(ra) * 16'(rb);
            bus.a = ra; bus.b = rb; bus.in_valid = 1'b1;
            bus.out_ready = 1'($urandom);
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                $display("[TB] FAIL b2b_ready%0d: got %b want 1", k, bus.in_ready);
                miscompares++;
            end
            tick;
            issued++;
            bus.in_valid = 1'b0;
            bus.a = 8'($urandom); bus.b = 8'($urandom);
            cyc = 0;
            while (cyc < 200) begin
                bus.out_ready = 1'($urandom);
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) break;
                tick;
                cyc++;
            end
            vectors++;
            if (cyc >= 200 || bus.p !== want) begin
                $display("[TB] FAIL b2b_p%0d: got %h want %h (%0d cycles)", k, bus.p, want, cyc);
                miscompares++;
            end
            tick;
            received++;
            vectors++;
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
                $display("[TB] FAIL b2b_dup%0d: got vld=%b busy=%b want 0 0", k, bus.out_valid, bus.busy);
                miscompares++;
            end
        end
        vectors++;
        if (received != issued || issued != 200) begin
            $display("[TB] FAIL b2b_count: got %0d products for %0d requests want 200", received, issued);
            miscompares++;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset;
        test_basic;
        test_max;
        test_width16;
        test_backpressure;
        test_reset_mid_run;
        test_zero;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
